// File: rtl/multiword_add_seq.sv
// multiword_add_seq
//   Multi-cycle wide adder controller. One shared 4-bit ripple-carry slice is
//   stepped over NSLICE operand nibbles, least-significant nibble first. The
//   carry is registered between slices, so W = 4*NSLICE bits take NSLICE
//   cycles of RUN.
//
//   Build option: define ADD_SUB_EN to add the sub port and subtract support.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start_valid  requester presents op_a/op_b/cin (and sub with ADD_SUB_EN)
//   start_ready  high only in IDLE, including while in reset
//   op_a, op_b   W-bit operands, sampled at accept only
//   cin          carry into slice 0 (ignored when sub=1)
//   sub          subtract select, present only with ADD_SUB_EN
//   res_valid    high only in DONE
//   res_ready    consumer accepts the result (ignored outside DONE)
//   sum          registered W-bit result, held until the next accept
//   cout         carry out of the last slice (1 = no borrow when subtracting)
//   busy         high whenever not IDLE
module multiword_add_seq #(
  parameter int NSLICE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [4*NSLICE-1:0]   op_a,
  input  logic [4*NSLICE-1:0]   op_b,
  input  logic                  cin,
`ifdef ADD_SUB_EN
  input  logic                  sub,
`endif
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [4*NSLICE-1:0]   sum,
  output logic                  cout,
  output logic                  busy
);

  localparam int W  = 4 * NSLICE;
  localparam int IW = $clog2(NSLICE);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
`ifdef ADD_SUB_EN
  logic          sub_r;
`endif

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [3:0] s4;
  logic       c4;
  logic       accept;
  logic       first_carry;

  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign accept      = start_valid && start_ready;

`ifdef ADD_SUB_EN
  // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
  assign first_carry = sub ? 1'b1 : cin;
`else
  assign first_carry = cin;
`endif

  always_comb begin
    a_nib = a_r[{idx, 2'b00} +: 4];
`ifdef ADD_SUB_EN
    b_nib = sub_r ? ~b_r[{idx, 2'b00} +: 4] : b_r[{idx, 2'b00} +: 4];
`else
    b_nib = b_r[{idx, 2'b00} +: 4];
`endif
    {c4, s4} = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
`ifdef ADD_SUB_EN
      sub_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r   <= op_a;
            b_r   <= op_b;
`ifdef ADD_SUB_EN
            sub_r <= sub;
`endif
            sum   <= '0;
            carry <= first_carry;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[{idx, 2'b00} +: 4] <= s4;
          carry <= c4;
          idx   <= idx + IW'(1);
          if (idx == IW'(NSLICE - 1)) begin
            cout  <= c4;
            state <= DONE;
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// tb_multiword_add_seq
//   Directed-vector bench for multiword_add_seq with NSLICE=4 (16-bit).
//   Define ADD_SUB_EN for both bench and design to cover subtraction.
module tb_multiword_add_seq;

  localparam int NSLICE = 4;
  localparam int W      = 4 * NSLICE;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
`ifdef ADD_SUB_EN
  logic         sub;
`endif
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks = 0;
  int errors = 0;

  multiword_add_seq #(.NSLICE(NSLICE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .cin         (cin),
`ifdef ADD_SUB_EN
    .sub         (sub),
`endif
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present an operation at a negedge and confirm it is taken at the next edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(negedge clk);
    op_a        = a;
    op_b        = b;
    cin         = c;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_ready_low", 32'(start_ready), 32'd0);
    start_valid = 1'b0;
    op_a        = '1;
    op_b        = '1;
    cin         = 1'b1;
  endtask

  // Step exactly NSLICE edges after accept; res_valid must rise only on the last.
  task automatic wait_done(input logic [W-1:0] es, input logic ec, input bit chk_carry);
    for (int i = 1; i <= NSLICE; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("res_valid_edge%0d", i), 32'(res_valid), (i == NSLICE) ? 32'd1 : 32'd0);
      check($sformatf("busy_edge%0d", i), 32'(busy), 32'd1);
      if (chk_carry) check($sformatf("slice_carry%0d", i), 32'(dut.carry), 32'd1);
    end
    check("sum", 32'(sum), 32'(es));
    check("cout", 32'(cout), 32'(ec));
  endtask

  task automatic release_result(input logic [W-1:0] es, input logic ec);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("rel_res_valid", 32'(res_valid), 32'd0);
    check("rel_busy", 32'(busy), 32'd0);
    check("rel_start_ready", 32'(start_ready), 32'd1);
    check("rel_sum_held", 32'(sum), 32'(es));
    check("rel_cout_held", 32'(cout), 32'(ec));
  endtask

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    op_a        = '0;
    op_b        = '0;
    cin         = 1'b0;
`ifdef ADD_SUB_EN
    sub         = 1'b0;
`endif

    // Reset held 3 cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_start_ready", 32'(start_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(start_ready), 32'd1);

    // Basic add and latency
    launch(16'h1234, 16'h4321, 1'b0);
    wait_done(16'h5555, 1'b0, 1'b0);
    release_result(16'h5555, 1'b0);

    // Carry rippling through every slice, full-width overflow
    launch(16'hFFFF, 16'h0001, 1'b0);
    wait_done(16'h0000, 1'b1, 1'b1);
    release_result(16'h0000, 1'b1);

    // cin feeds slice 0
    launch(16'h0000, 16'h0000, 1'b1);
    wait_done(16'h0001, 1'b0, 1'b0);
    release_result(16'h0001, 1'b0);

    // Backpressure with start_valid held high throughout
    launch(16'h1111, 16'h2222, 1'b0);
    wait_done(16'h3333, 1'b0, 1'b0);
    @(negedge clk);
    op_a        = 16'h0102;
    op_b        = 16'h0304;
    cin         = 1'b0;
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_sum", 32'(sum), 32'h3333);
      check("bp_cout", 32'(cout), 32'd0);
      check("bp_start_ready", 32'(start_ready), 32'd0);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_done_to_idle", 32'(busy), 32'd0);
    check("bp_valid_drop", 32'(res_valid), 32'd0);
    @(negedge clk);
    res_ready = 1'b0;
    @(posedge clk);
    #1;
    check("bp_next_accept", 32'(busy), 32'd1);
    start_valid = 1'b0;
    wait_done(16'h0406, 1'b0, 1'b0);
    release_result(16'h0406, 1'b0);

    // Reset while RUN sits at idx=2
    launch(16'hAAAA, 16'h5555, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_idx", 32'(dut.idx), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(start_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    launch(16'h0F0F, 16'h00F1, 1'b0);
    wait_done(16'h1000, 1'b0, 1'b0);
    release_result(16'h1000, 1'b0);

`ifdef ADD_SUB_EN
    sub = 1'b1;
    launch(16'h0007, 16'h0005, 1'b1);
    sub = 1'b0;
    wait_done(16'h0002, 1'b1, 1'b0);
    release_result(16'h0002, 1'b1);

    sub = 1'b1;
    launch(16'h0005, 16'h0007, 1'b1);
    sub = 1'b0;
    wait_done(16'hFFFE, 1'b0, 1'b0);
    release_result(16'hFFFE, 1'b0);

    sub = 1'b1;
    launch(16'h0007, 16'h0005, 1'b0);
    sub = 1'b0;
    wait_done(16'h0002, 1'b1, 1'b0);
    release_result(16'h0002, 1'b1);

    sub = 1'b1;
    launch(16'h0005, 16'h0007, 1'b0);
    sub = 1'b0;
    wait_done(16'hFFFE, 1'b0, 1'b0);
    release_result(16'hFFFE, 1'b0);

    sub = 1'b0;
    launch(16'h0007, 16'h0005, 1'b1);
    wait_done(16'h000D, 1'b0, 1'b0);
    release_result(16'h000D, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
